// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the counter sequencing controller.
package counter_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 4;

    // Command opcodes carried on cmd_op
    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_START    = 3'd1;
    localparam logic [2:0] OP_STOP     = 3'd2;
    localparam logic [2:0] OP_STEP     = 3'd3;
    localparam logic [2:0] OP_LOAD     = 3'd4;
    localparam logic [2:0] OP_DIR_UP   = 3'd5;
    localparam logic [2:0] OP_DIR_DOWN = 3'd6;
    localparam logic [2:0] OP_CLEAR    = 3'd7;

    // Controller states, encoded as seen on run_state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } run_state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle enable pulse every DIV_MAX+1 enabled cycles.
module tick_gen #(
    parameter int unsigned DIV_MAX = 212,
    parameter int unsigned DIV_W   = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [DIV_W-1:0] DivMax = DIV_W'(DIV_MAX);

    logic [DIV_W-1:0] div_q;

    // Tick is decoded from the registered count so it lines up with the terminal cycle
    assign tick_o = en_i & (div_q == DivMax);

    // Divider register: clear has priority, wraps to zero on the terminal value
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            div_q <= '0;
        end else if (en_i) begin
            div_q <= tick_o ? '0 : div_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer for a small wrap-around counter paced by tick_gen.
module counter_seq_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned DIV_MAX = 212,
    parameter int unsigned DIV_W   = 26,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_data,
    output logic             tick,
    output logic [CNT_W-1:0] counter_out,
    output logic             tc_pulse,
    output logic             dir,
    output logic [1:0]       run_state
);

    run_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             tc_q;

    logic             acc;
    logic             upd_en;
    logic [CNT_W-1:0] cnt_step;
    logic             wraps;
    logic             div_en;
    logic             div_clr;

    assign cmd_ready = (state_q != ST_STEP);
    assign acc       = cmd_valid & cmd_ready;

    // Divider only runs in RUN; leaving RUN or STOP restarts its phase from zero
    assign div_en  = (state_q == ST_RUN);
    assign div_clr = (state_q != ST_RUN) | (acc & (cmd_op == OP_STOP));

    tick_gen #(
        .DIV_MAX(DIV_MAX),
        .DIV_W  (DIV_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en_i  (div_en),
        .clr_i (div_clr),
        .tick_o(tick)
    );

    // Candidate count update using the currently registered direction
    always_comb begin
        upd_en   = tick | (state_q == ST_STEP);
        cnt_step = dir_q ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
        wraps    = dir_q ? (cnt_q == {CNT_W{1'b1}}) : (cnt_q == '0);
    end

    // FSM, counter, direction and wrap pulse, all registered together
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b1;
            tc_q    <= 1'b0;
        end else begin
            tc_q <= 1'b0;

            // LOAD/CLEAR beat a coincident tick; the dropped update never pulses tc
            if (acc && cmd_op == OP_LOAD) begin
                cnt_q <= cmd_data;
            end else if (acc && cmd_op == OP_CLEAR) begin
                cnt_q <= '0;
            end else if (upd_en) begin
                cnt_q <= cnt_step;
                tc_q  <= wraps;
            end

            if (acc && cmd_op == OP_DIR_UP) begin
                dir_q <= 1'b1;
            end else if (acc && cmd_op == OP_DIR_DOWN) begin
                dir_q <= 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (acc && cmd_op == OP_START) begin
                        state_q <= ST_RUN;
                    end else if (acc && cmd_op == OP_STEP) begin
                        state_q <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (acc && cmd_op == OP_STOP) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign counter_out = cnt_q;
    assign tc_pulse    = tc_q;
    assign dir         = dir_q;
    assign run_state   = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a scoreboard of expected counter updates.
module tb_counter_seq_ctrl;
    import counter_ctrl_pkg::*;

    localparam int unsigned DIV_MAX = 3;
    localparam int unsigned DIV_W   = 26;
    localparam int unsigned CNT_W   = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_data;
    logic             tick;
    logic [CNT_W-1:0] counter_out;
    logic             tc_pulse;
    logic             dir;
    logic [1:0]       run_state;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             tc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    counter_seq_ctrl #(
        .DIV_MAX(DIV_MAX),
        .DIV_W  (DIV_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .tick       (tick),
        .counter_out(counter_out),
        .tc_pulse   (tc_pulse),
        .dir        (dir),
        .run_state  (run_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one command for a single edge; the controller is ready whenever this is used
    task automatic send(input logic [2:0] op, input logic [CNT_W-1:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cyc();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
    endtask

    task automatic push(input logic [CNT_W-1:0] cnt, input logic tc);
        exp_t e;
        e.cnt = cnt;
        e.tc  = tc;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_cnt"}, 32'(counter_out), 32'(e.cnt));
            chk({tag, "_tc"}, 32'(tc_pulse), 32'(e.tc));
        end
    endtask

    // Wait (bounded) for the tick, check its distance, then compare the resulting update
    task automatic upd(input string tag, input int exp_wait);
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_wait"}, 32'(n), 32'(exp_wait));
        cyc();
        pop_chk(tag);
    endtask

    initial begin
        if (DIV_MAX >= (64'd1 << DIV_W)) begin
            $display("FAIL div_w_check observed=%0d expected=<%0d", DIV_MAX, 64'd1 << DIV_W);
            $fatal(1, "DIV_MAX does not fit in DIV_W");
        end

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset values
        chk("rst_cnt",   32'(counter_out), 32'd0);
        chk("rst_dir",   32'(dir),         32'd1);
        chk("rst_state", 32'(run_state),   32'(ST_IDLE));
        chk("rst_ready", 32'(cmd_ready),   32'd1);
        chk("rst_tick",  32'(tick),        32'd0);
        chk("rst_tc",    32'(tc_pulse),    32'd0);

        // Basic run: a tick every DIV_MAX+1 cycles
        send(OP_START, '0);
        chk("start_state", 32'(run_state), 32'(ST_RUN));
        push(4'd1, 1'b0);
        push(4'd2, 1'b0);
        push(4'd3, 1'b0);
        upd("run1", 3);
        upd("run2", 3);
        upd("run3", 3);

        // Wrap upward, then downward
        send(OP_STOP, '0);
        chk("stop_state", 32'(run_state), 32'(ST_IDLE));
        send(OP_LOAD, 4'd14);
        chk("load14", 32'(counter_out), 32'd14);
        send(OP_START, '0);
        push(4'd15, 1'b0);
        push(4'd0, 1'b1);
        upd("up15", 3);
        upd("upwrap", 3);
        cyc();
        chk("tc_one_cycle", 32'(tc_pulse), 32'd0);
        send(OP_DIR_DOWN, '0);
        chk("dir_down", 32'(dir), 32'd0);
        push(4'd15, 1'b1);
        upd("downwrap", 1);
        send(OP_STOP, '0);
        send(OP_DIR_UP, '0);
        chk("dir_up", 32'(dir), 32'd1);

        // STEP from IDLE: one busy cycle, single update, no tick
        send(OP_STEP, '0);
        chk("step_state", 32'(run_state), 32'(ST_STEP));
        chk("step_ready", 32'(cmd_ready), 32'd0);
        chk("step_tick",  32'(tick),      32'd0);
        push(4'd0, 1'b1);
        cyc();
        pop_chk("step_wrap");
        chk("step_back", 32'(run_state), 32'(ST_IDLE));
        chk("step_ready_back", 32'(cmd_ready), 32'd1);
        send(OP_STEP, '0);
        push(4'd1, 1'b0);
        cyc();
        pop_chk("step2");

        // STEP during RUN is ignored
        send(OP_START, '0);
        send(OP_STEP, '0);
        chk("run_step_state", 32'(run_state), 32'(ST_RUN));
        chk("run_step_cnt", 32'(counter_out), 32'd1);
        push(4'd2, 1'b0);
        upd("run_after_step", 2);

        // LOAD coinciding with tick wins
        cyc();
        cyc();
        cyc();
        chk("load_tick_pre", 32'(tick), 32'd1);
        push(4'd9, 1'b0);
        send(OP_LOAD, 4'd9);
        pop_chk("load_on_tick");

        // STOP coinciding with tick still applies the update
        cyc();
        cyc();
        cyc();
        chk("stop_tick_pre", 32'(tick), 32'd1);
        push(4'd10, 1'b0);
        send(OP_STOP, '0);
        pop_chk("stop_on_tick");
        chk("stop_tick_state", 32'(run_state), 32'(ST_IDLE));

        // STOP mid-phase then START restarts the divider from zero
        send(OP_START, '0);
        cyc();
        cyc();
        send(OP_STOP, '0);
        chk("midstop_cnt", 32'(counter_out), 32'd10);
        send(OP_START, '0);
        push(4'd11, 1'b0);
        upd("restart", 3);

        // Reset mid-RUN overrides a pending LOAD
        send(OP_DIR_DOWN, '0);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 4'd5;
        cyc();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
        chk("rst2_cnt",   32'(counter_out), 32'd0);
        chk("rst2_dir",   32'(dir),         32'd1);
        chk("rst2_state", 32'(run_state),   32'(ST_IDLE));
        chk("rst2_ready", 32'(cmd_ready),   32'd1);
        chk("rst2_tick",  32'(tick),        32'd0);
        chk("rst2_tc",    32'(tc_pulse),    32'd0);

        // Divider phase is fresh after reset; CLEAR in RUN keeps the state
        send(OP_START, '0);
        push(4'd1, 1'b0);
        upd("post_rst", 3);
        send(OP_CLEAR, '0);
        chk("clear_cnt", 32'(counter_out), 32'd0);
        chk("clear_state", 32'(run_state), 32'(ST_RUN));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
